input_event_scheduler: RTL
==========================

// Module: input_event_scheduler
// PURPOSE
//  Drives the ~1 kHz en_sample tick shared by all debouncers and collects their
//  db_pulse outputs (coin, select, cancel, ...) into one ordered event stream.
//  Round-robin arbitrates pending pulses into a small FIFO read by the vending FSM
//  over a valid/ready handshake. Sits between the debouncer bank and the main FSM.
// PARAMETERS
//  N_IN        4            number of debounced pulse inputs (>=2)
//  CLK_HZ      100_000_000  system clock frequency
//  SAMPLE_HZ   1000         en_sample rate; DIV = CLK_HZ/SAMPLE_HZ (>=2)
//  FIFO_DEPTH  4            event FIFO entries (power of 2)
//  LOCKOUT_TK  50           en_sample ticks of per-input lockout (LOCKOUT_EN only)
// PORTS
//  clk        in   1             system clock
//  rst        in   1             asynchronous reset, active-high
//  en_sample  out  1             one-cycle tick every DIV clocks, to all debouncers
//  pulse_in   in   N_IN          db_pulse bits from the debouncers
//  evt_valid  out  1             FIFO head holds an event
//  evt_id     out  IDW           input index of head event, IDW=$clog2(N_IN)
//  evt_ready  in   1             consumer accepts head this cycle
//  overflow   out  1             sticky: an input pulse was coalesced/lost
//  ovf_clr    in   1             clears overflow
// BEHAVIOUR
//  Reset (async): div_cnt=0, pend=0, rr_ptr=0, FIFO empty; en_sample=0,
//   evt_valid=0, evt_id=0, overflow=0. Reset mid-operation discards all events.
//  Prescaler: div_cnt counts 0..DIV-1 and wraps; en_sample=1 when div_cnt==DIV-1
//   (registered decode), so first tick in cycle DIV-1 after reset release.
//  Pending: pend[i] set on pulse_in[i]; cleared the cycle i is granted.
//   pulse_in[i] while pend[i]=1 and i not granted that cycle -> coalesced, overflow=1.
//  Arbiter: each cycle, if pend!=0 and FIFO can accept, grant first set bit
//   at/after rr_ptr (wrapping); push its index; rr_ptr <= grant+1 (mod N_IN).
//   At most one push per cycle. pend is held while FIFO cannot accept.
//  FIFO accept rule: push allowed if !full, or full and pop in same cycle.
//   Simultaneous push+pop when empty is impossible (no fall-through).
//  Pop: evt_valid & evt_ready. evt_id registered head, stable while valid & !ready.
//  Latency: pulse_in at cycle t (FIFO empty, no contention) -> evt_valid at t+2.
//  overflow: set has priority over ovf_clr in same cycle; otherwise cleared.
//  Pointers: wrap at FIFO_DEPTH; full/empty via extra pointer MSB.
// CONFIGURATION
//  `define INPUT_LOCKOUT_EN: per-input down-counter loaded with LOCKOUT_TK on grant,
//   decremented on en_sample; pulse_in[i] ignored (no pend, no overflow) while
//   its counter !=0. Reset clears all counters.
//  Without INPUT_LOCKOUT_EN: no counters; every pulse is eligible immediately.
// STRUCTURE
//  Shared package vm_pkg: event id constants (EVT_COIN, EVT_SELECT, EVT_CANCEL,
//   EVT_REFUND), N_IN default, CLK_HZ, SAMPLE_HZ.
//  Sub-module: event_fifo (sync FIFO, push/pop/full/empty, registered head).
//  Prescaler, pending regs, round-robin grant and lockout live in this module.
// TESTING
//  1 CLK_HZ=1000,SAMPLE_HZ=100: en_sample high exactly at cycles 9,19,29 after rst.
//  2 pulse_in=4'b0010 one cycle, evt_ready=1 -> evt_valid at t+2, evt_id=1, one beat.
//  3 pulse_in=4'b1011 same cycle, rr_ptr=0, ready=1 -> ids 0,1,3 in order; rr_ptr=0.
//  4 evt_ready=0, 6 separate single pulses, DEPTH=4 -> 4 queued, rest held in pend;
//    raise ready -> all 6 drained in arbitration order, overflow=0.
//  5 pulse_in[2] twice while pend[2] held (FIFO full) -> overflow=1; ovf_clr -> 0.
//  6 INPUT_LOCKOUT_EN, LOCKOUT_TK=3: repeat pulse_in[0] within 3 ticks dropped,
//    after 3rd en_sample accepted; without macro both pulses produce events.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared constants for the vending-machine input path: event ids, default
// rates and sizes, and the round-robin pointer advance helper.
package vm_pkg;

    localparam int N_IN_DEF       = 4;
    localparam int CLK_HZ_DEF     = 100_000_000;
    localparam int SAMPLE_HZ_DEF  = 1000;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int LOCKOUT_TK_DEF = 50;

    typedef enum logic [1:0] {
        EVT_COIN   = 2'd0,
        EVT_SELECT = 2'd1,
        EVT_CANCEL = 2'd2,
        EVT_REFUND = 2'd3
    } evt_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO. The head entry is driven straight from the storage
// flops, so dout holds steady until the entry is popped. No fall-through.
module event_fifo
#(
    parameter int DW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          wr_en;
    logic          rd_en;

    // Pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/input_event_scheduler.sv
// Sample-tick prescaler plus round-robin collector of debounced pulses into an
// ordered event FIFO. Define INPUT_LOCKOUT_EN for per-input re-trigger lockout.
module input_event_scheduler
    import vm_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int SAMPLE_HZ  = SAMPLE_HZ_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef INPUT_LOCKOUT_EN
    , parameter int LOCKOUT_TK = LOCKOUT_TK_DEF
`endif
    , localparam int IDW = $clog2(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            en_sample,
    input  logic [N_IN-1:0] pulse_in,
    output logic            evt_valid,
    output logic [IDW-1:0]  evt_id,
    input  logic            evt_ready,
    output logic            overflow,
    input  logic            ovf_clr
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int DCW = $clog2(DIV);

    logic [DCW-1:0]  div_cnt_q, div_cnt_d;
    logic            en_sample_q, en_sample_d;
    logic [N_IN-1:0] pend_q, pend_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            overflow_q, overflow_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic [N_IN-1:0] grant_oh;
    logic [N_IN-1:0] eligible;
    logic [N_IN-1:0] pulse_acc;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            can_push;

    assign en_sample = en_sample_q;
    assign overflow  = overflow_q;
    assign evt_valid = ~fifo_empty;
    assign fifo_pop  = ~fifo_empty & evt_ready;
    assign can_push  = ~fifo_full | fifo_pop;

    // Tick is decoded from the next count so it lines up with div_cnt==DIV-1.
    always_comb begin
        div_cnt_d   = (div_cnt_q == DCW'(DIV - 1)) ? '0 : div_cnt_q + DCW'(1);
        en_sample_d = (div_cnt_d == DCW'(DIV - 1));
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_oh  = '0;
        for (int k = 0; k < N_IN; k++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + k) % N_IN);
            if (!grant_vld && can_push && pend_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        rr_ptr_d = grant_vld ? IDW'(rr_next(int'(grant_idx), N_IN)) : rr_ptr_q;
    end

`ifdef INPUT_LOCKOUT_EN
    localparam int LCW = $clog2(LOCKOUT_TK + 1);

    logic [LCW-1:0] lock_q [N_IN];
    logic [LCW-1:0] lock_d [N_IN];

    // A grant reloads the counter even if a tick lands in the same cycle.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            lock_d[i]   = lock_q[i];
            eligible[i] = (lock_q[i] == '0);
            if (grant_oh[i]) begin
                lock_d[i] = LCW'(LOCKOUT_TK);
            end else if (en_sample_q && lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - LCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                lock_q[i] <= '0;
            end
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign eligible = '1;
`endif

    // A pulse on an input being granted this cycle re-arms it rather than coalescing.
    always_comb begin
        pulse_acc  = pulse_in & eligible;
        pend_d     = pulse_acc | (pend_q & ~grant_oh);
        overflow_d = (|(pulse_acc & pend_q & ~grant_oh)) | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            en_sample_q <= 1'b0;
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            en_sample_q <= en_sample_d;
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    event_fifo #(
        .DW    (IDW),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant_vld),
        .din   (grant_idx),
        .pop   (fifo_pop),
        .dout  (evt_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
